div_8b: RTL
===========

DIV_8B -- requirements
Module: div_8b

Interface
REQ-001 SHALL declare parameter N_DVD, default 16, the dividend and quotient width.
REQ-002 SHALL declare parameter N_DVS, default 8, the divisor and remainder width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-low reset (low = reset).
REQ-005 SHALL have port inicio, input, 1 bit, start request sampled at rising clk.
REQ-006 SHALL have port dividendo, input, N_DVD bits, unsigned dividend.
REQ-007 SHALL have port divisor, input, N_DVS bits, unsigned divisor.
REQ-008 SHALL have port quociente, output, N_DVD bits, registered quotient.
REQ-009 SHALL have port resto, output, N_DVS bits, registered remainder.
REQ-010 SHALL have port fim, output, 1 bit, registered done flag.
REQ-011 SHALL have port erro, output, 1 bit, registered divide-by-zero flag.

Function
REQ-012 SHALL implement FSM states OCIOSO, CALC, FIM; reset state OCIOSO.
REQ-013 OCIOSO or FIM with inicio=1 at an edge SHALL latch dividendo/divisor, clear the N_DVS+1-bit partial remainder and the 5-bit iteration counter, clear fim/erro, and enter CALC.
REQ-014 CALC SHALL perform one restoring step per clock, MSB first: shift in the next dividend bit, trial-subtract the divisor, keep the difference and set the quotient bit when non-negative, otherwise restore and clear the bit.
REQ-015 CALC SHALL last exactly N_DVD clocks; fim SHALL be high after the 17th edge counting the sampling edge as edge 1 (default widths).
REQ-016 On entry to FIM, quociente and resto SHALL update, with resto = partial remainder[N_DVS-1:0], and fim SHALL assert.
REQ-017 quociente, resto and erro SHALL hold their values from FIM entry until the next accepted start or reset; quociente and resto SHALL NOT change during CALC.
REQ-018 fim SHALL remain high in FIM indefinitely while inicio=0.
REQ-019 inicio SHALL be ignored during CALC; operand changes after the sampling edge SHALL NOT affect the result.
REQ-020 Results SHALL satisfy dividendo = quociente*divisor + resto with resto < divisor whenever divisor != 0.
REQ-021 divisor = 0 SHALL yield quociente = all ones and resto = dividendo[N_DVS-1:0].

Reset
REQ-022 rst low SHALL immediately force state OCIOSO and clear quociente, resto, fim, erro, counter and working registers, including mid-CALC.
REQ-023 After rst deasserts, no operation SHALL start until inicio is sampled high.

Configuration
REQ-024 With macro DIV_ZERO_CHECK_EN defined, a start with divisor = 0 SHALL go directly to FIM at the sampling edge with erro=1 and the REQ-021 values, so fim is high one edge after the start.
REQ-025 Without DIV_ZERO_CHECK_EN, erro SHALL be tied to 0 and divisor = 0 SHALL run the full N_DVD-cycle CALC, producing the REQ-021 values.

Structure
REQ-026 Package div_pkg SHALL hold the FSM state typedef, the default widths and the counter width constant.
REQ-027 The combinational single-step shift/subtract/restore SHALL be a sub-module named div_passo, instantiated once.

Verification
REQ-028 Scenario 1: 300 / 12, start pulse -> fim high at edge 17; quociente=25, resto=0, erro=0.
REQ-029 Scenario 2: 65535 / 255 -> quociente=257, resto=0; then 1000 / 7 -> quociente=142, resto=6.
REQ-030 Scenario 3: 5 / 9 -> quociente=0, resto=5; fim still high 100 clocks later with values unchanged.
REQ-031 Scenario 4: 1234 / 0 -> with DIV_ZERO_CHECK_EN: fim at edge 1, erro=1, quociente=16'hFFFF, resto=8'hD2; without it: fim at edge 17, erro=0, same values.
REQ-032 Scenario 5: rst low at CALC edge 8 -> all outputs 0 immediately; a new 100 / 10 start -> quociente=10, resto=0.
REQ-033 Scenario 6: inicio reasserted and operands changed during CALC -> ignored, original result delivered; a start issued from FIM runs the new operands.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider.
// Holds the FSM state type, the default operand widths and the width of the
// iteration counter used by div_8b.
package div_pkg;

  localparam int N_DVD_DEF = 16;  // default dividend / quotient width
  localparam int N_DVS_DEF = 8;   // default divisor / remainder width
  localparam int CNT_W     = 5;   // iteration counter width (holds 0..N_DVD-1)

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CALC   = 2'd1,
    FIM    = 2'd2
  } estado_t;

endpackage

// File: rtl/div_passo.sv
// One combinational step of restoring division.
// Shifts the next dividend bit into the partial remainder, trial-subtracts
// the divisor, and keeps the difference when it is non-negative (quotient
// bit 1) or the shifted value otherwise (quotient bit 0).
// Ports:
//   resto_ent  partial remainder before the step (N_DVS+1 bits)
//   bit_ent    next dividend bit, MSB first
//   divisor    divisor (N_DVS bits)
//   resto_sai  partial remainder after the step (N_DVS+1 bits)
//   bit_q      quotient bit produced by this step
module div_passo
  import div_pkg::*;
#(
  parameter int N_DVS = N_DVS_DEF
) (
  input  logic [N_DVS:0]   resto_ent,
  input  logic             bit_ent,
  input  logic [N_DVS-1:0] divisor,
  output logic [N_DVS:0]   resto_sai,
  output logic             bit_q
);

  logic [N_DVS+1:0] deslocado;
  logic [N_DVS+2:0] diferenca;

  always_comb begin
    deslocado = {resto_ent, bit_ent};
    // One extra top bit acts as the borrow/sign of the trial subtraction.
    diferenca = {1'b0, deslocado} - {3'b000, divisor};
    bit_q     = ~diferenca[N_DVS+2];
    // The kept value is always below 2*divisor, so N_DVS+1 bits suffice.
    resto_sai = (N_DVS+1)'(bit_q ? diferenca[N_DVS+1:0] : deslocado);
  end

endmodule

// File: rtl/div_8b.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// A start (inicio high while not calculating) latches the operands; N_DVD
// clocks later quociente/resto are loaded and fim rises. Results hold until
// the next accepted start or reset. Divide by zero yields an all-ones
// quotient and the low N_DVS dividend bits as remainder.
// Optional build macro DIV_ZERO_CHECK_EN: a start with divisor = 0 finishes
// at the sampling edge with erro = 1; without it erro is tied low and the
// full calculation runs.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   inicio     start request
//   dividendo  unsigned dividend (N_DVD bits)
//   divisor    unsigned divisor (N_DVS bits)
//   quociente  registered quotient (N_DVD bits)
//   resto      registered remainder (N_DVS bits)
//   fim        registered done flag
//   erro       registered divide-by-zero flag
module div_8b
  import div_pkg::*;
#(
  parameter int N_DVD = N_DVD_DEF,
  parameter int N_DVS = N_DVS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic [N_DVD-1:0] dividendo,
  input  logic [N_DVS-1:0] divisor,
  output logic [N_DVD-1:0] quociente,
  output logic [N_DVS-1:0] resto,
  output logic             fim,
  output logic             erro
);

  estado_t          estado, estado_prox;
  logic [N_DVD-1:0] dvd_q;     // dividend bits shift out at the top, quotient bits in at the bottom
  logic [N_DVS-1:0] dvs_q;
  logic [N_DVS:0]   par_q;
  logic [N_DVS:0]   par_prox;
  logic [CNT_W-1:0] cnt_q;
  logic             bit_q;
  logic             aceita;
  logic             ultimo;
  logic             div_zero;

  div_passo #(.N_DVS(N_DVS)) u_passo (
    .resto_ent (par_q),
    .bit_ent   (dvd_q[N_DVD-1]),
    .divisor   (dvs_q),
    .resto_sai (par_prox),
    .bit_q     (bit_q)
  );

  assign aceita = inicio && (estado != CALC);
  assign ultimo = (cnt_q == CNT_W'(N_DVD - 1));

`ifdef DIV_ZERO_CHECK_EN
  assign div_zero = (divisor == '0);
`else
  assign div_zero = 1'b0;
  assign erro     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) estado <= OCIOSO;
    else      estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO, FIM: if (aceita) estado_prox = div_zero ? FIM : CALC;
      CALC:        if (ultimo) estado_prox = FIM;
      default:     estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      par_q     <= '0;
      cnt_q     <= '0;
      quociente <= '0;
      resto     <= '0;
      fim       <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      erro      <= 1'b0;
`endif
    end else if (aceita) begin
      dvd_q <= dividendo;
      dvs_q <= divisor;
      par_q <= '0;
      cnt_q <= '0;
      fim   <= div_zero;
`ifdef DIV_ZERO_CHECK_EN
      erro  <= div_zero;
      // Zero divisor short-circuits straight to the result.
      if (div_zero) begin
        quociente <= '1;
        resto     <= dividendo[N_DVS-1:0];
      end
`endif
    end else if (estado == CALC) begin
      dvd_q <= {dvd_q[N_DVD-2:0], bit_q};
      par_q <= par_prox;
      cnt_q <= cnt_q + 1'b1;
      if (ultimo) begin
        quociente <= {dvd_q[N_DVD-2:0], bit_q};
        resto     <= par_prox[N_DVS-1:0];
        fim       <= 1'b1;
      end
    end
  end

endmodule
